// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the ID-stage operand fields, the ID/EX and EXE/MEM destination
//   fields and the branch-resolve strobe going into the hazard controller,
//   plus the stage freeze/flush controls and debug counters coming out.
//   master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic             src1_used;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             freeze;
  logic             flush_if;
  logic             flush_id;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output src1, src2, two_src, src1_used,
    output exe_dest, exe_wb_en, exe_mem_read,
    output mem_dest, mem_wb_en, branch_taken,
    input  freeze, flush_if, flush_id, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  src1, src2, two_src, src1_used,
    input  exe_dest, exe_wb_en, exe_mem_read,
    input  mem_dest, mem_wb_en, branch_taken,
    output freeze, flush_if, flush_id, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Freeze/flush generator for the IF, IF/ID and ID/EX stages of the 5-stage
//   core. Detects RAW hazards between the ID-stage sources and the ID/EX and
//   EXE/MEM destinations, holds a FLUSH_CYCLES-long flush window after a taken
//   branch and keeps saturating stall/flush event counters for debug.
//   Build option: define PIPE_HAZARD_FWD_EN when the forwarding unit is
//   present; only load-use hazards against ID/EX then cause a stall.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Last value of the window counter before returning to RUN; the branch
  // cycle itself is the first cycle of the window.
  localparam logic [2:0]       FCNT_LAST   = 3'(FLUSH_CYCLES - 1);
  localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // Source/destination match for one producer stage; all four index bits
  // compared, R15 is an ordinary register here.
  function automatic logic f_src_hit(
    input logic [3:0] i_src1,
    input logic [3:0] i_src2,
    input logic       i_src1_used,
    input logic       i_two_src,
    input logic [3:0] i_dest,
    input logic       i_wb_en
  );
    return i_wb_en & ((i_src1_used & (i_src1 == i_dest)) |
                      (i_two_src   & (i_src2 == i_dest)));
  endfunction

  state_t           r_state;
  logic [2:0]       r_fcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hit_exe;
  logic w_hazard;
  logic w_flush;
  logic w_freeze;
  logic w_flush_if;
  logic w_flush_id;
  logic w_unused;

  assign w_hit_exe = f_src_hit(hz.src1, hz.src2, hz.src1_used, hz.two_src,
                               hz.exe_dest, hz.exe_wb_en);

`ifdef PIPE_HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load in EXE cannot be bypassed.
  assign w_hazard = w_hit_exe & hz.exe_mem_read;
  assign w_unused = ^{hz.mem_dest, hz.mem_wb_en};
`else
  // No bypass paths: wait until the producer has left EXE and MEM.
  logic w_hit_mem;
  assign w_hit_mem = f_src_hit(hz.src1, hz.src2, hz.src1_used, hz.two_src,
                               hz.mem_dest, hz.mem_wb_en);
  assign w_hazard  = w_hit_exe | w_hit_mem;
  assign w_unused  = hz.exe_mem_read;
`endif

  assign w_flush = hz.branch_taken | (r_state == ST_FLUSH);

  // Stage controls: branch flush beats hazard stall; a stall also bubbles ID/EX.
  always_comb begin
    w_freeze   = 1'b0;
    w_flush_if = 1'b0;
    w_flush_id = 1'b0;
    if (w_flush) begin
      w_flush_if = 1'b1;
      w_flush_id = 1'b1;
    end else if (w_hazard) begin
      w_freeze   = 1'b1;
      w_flush_id = 1'b1;
    end else begin
      w_freeze   = 1'b0;
      w_flush_if = 1'b0;
      w_flush_id = 1'b0;
    end
  end

  // Control FSM: a taken branch (re)starts the flush window from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else if (hz.branch_taken) begin
      if (MULTI_FLUSH) begin
        r_state <= ST_FLUSH;
        r_fcnt  <= 3'd1;
      end else begin
        r_state <= ST_RUN;
        r_fcnt  <= 3'd0;
      end
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          r_state <= w_hazard ? ST_STALL : ST_RUN;
          r_fcnt  <= 3'd0;
        end
        ST_FLUSH: begin
          if (r_fcnt >= FCNT_LAST) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
          end else begin
            r_fcnt  <= r_fcnt + 3'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_fcnt  <= 3'd0;
        end
      endcase
    end
  end

  // Debug counters: freeze cycles and taken branches, held at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_freeze && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (hz.branch_taken && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hz.freeze    = w_freeze;
  assign hz.flush_if  = w_flush_if;
  assign hz.flush_id  = w_flush_id;
  assign hz.state     = r_state;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Two instances: u_dut (FLUSH_CYCLES=3, CNT_W=4) and u_dut1 (defaults
//   FLUSH_CYCLES=1, CNT_W=16), driven with identical inputs. Expected values
//   follow PIPE_HAZARD_FWD_EN when it is defined.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if #(.CNT_W(4))  hz0 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) hz1 ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz0.slave)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (hz1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two_src;
    logic       src1_used;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_read;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       exp_nofwd;
    logic       exp_fwd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic used,
                       input logic [3:0] ed, input logic ew, input logic emr,
                       input logic [3:0] md, input logic mw, input logic br);
    hz0.src1 = s1;          hz1.src1 = s1;
    hz0.src2 = s2;          hz1.src2 = s2;
    hz0.two_src = two;      hz1.two_src = two;
    hz0.src1_used = used;   hz1.src1_used = used;
    hz0.exe_dest = ed;      hz1.exe_dest = ed;
    hz0.exe_wb_en = ew;     hz1.exe_wb_en = ew;
    hz0.exe_mem_read = emr; hz1.exe_mem_read = emr;
    hz0.mem_dest = md;      hz1.mem_dest = md;
    hz0.mem_wb_en = mw;     hz1.mem_wb_en = mw;
    hz0.branch_taken = br;  hz1.branch_taken = br;
  endtask

  task automatic drive_idle();
    drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Load-use hazard on src1=R3 against ID/EX, optionally with a branch.
  task automatic drive_hazard(input logic br);
    drive(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, br);
  endtask

  // Called at posedge+1; reset pulse lies completely between clock edges.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"no_wb",     4'd0,  4'd0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"exe_alu",   4'd3,  4'd0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"exe_load",  4'd3,  4'd0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{"src1_nuse", 4'd3,  4'd0, 1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"src2_exe",  4'd1,  4'd9, 1'b1, 1'b1, 4'd9,  1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"src2_nuse", 4'd1,  4'd9, 1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"mem_src1",  4'd5,  4'd0, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"mem_no_wb", 4'd5,  4'd0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"r15_load",  4'd15, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"msb_diff",  4'd11, 4'd0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"mem_src2",  4'd2,  4'd7, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0};

    // Reset state with all inputs low
    drive_idle();
    #2;
    chk("rst_state",   32'(hz0.state),     32'd0);
    chk("rst_freeze",  32'(hz0.freeze),    32'd0);
    chk("rst_flush_if",32'(hz0.flush_if),  32'd0);
    chk("rst_flush_id",32'(hz0.flush_id),  32'd0);
    chk("rst_stall",   32'(hz0.stall_cnt), 32'd0);
    chk("rst_flushc",  32'(hz0.flush_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    next_cycle();

    // Table: combinational hazard detection, no branch
    for (int i = 0; i < 11; i++) begin
      logic exp_f;
      exp_f = FWD ? vecs[i].exp_fwd : vecs[i].exp_nofwd;
      drive(vecs[i].src1, vecs[i].src2, vecs[i].two_src, vecs[i].src1_used,
            vecs[i].exe_dest, vecs[i].exe_wb_en, vecs[i].exe_mem_read,
            vecs[i].mem_dest, vecs[i].mem_wb_en, 1'b0);
      #1;
      chk({vecs[i].name, "_freeze"},   32'(hz0.freeze),   32'(exp_f));
      chk({vecs[i].name, "_flush_id"}, 32'(hz0.flush_id), 32'(exp_f));
      chk({vecs[i].name, "_flush_if"}, 32'(hz0.flush_if), 32'd0);
      chk({vecs[i].name, "_freeze1"},  32'(hz1.freeze),   32'(exp_f));
      next_cycle();
    end

    // Producer moves from EXE into MEM
    drive_idle();
    reset_pulse();
    drive_hazard(1'b0);
    #1;
    chk("seq_c0_freeze",   32'(hz0.freeze),   32'd1);
    chk("seq_c0_flush_if", 32'(hz0.flush_if), 32'd0);
    next_cycle();
    chk("seq_c0_state", 32'(hz0.state), 32'd1);
    drive(4'd3, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    #1;
    chk("seq_c1_freeze", 32'(hz0.freeze), FWD ? 32'd0 : 32'd1);
    next_cycle();
    chk("seq_c1_state", 32'(hz0.state), FWD ? 32'd0 : 32'd1);
    drive_idle();
    #1;
    chk("seq_c2_freeze", 32'(hz0.freeze), 32'd0);
    next_cycle();
    chk("seq_c2_state",  32'(hz0.state),     32'd0);
    chk("seq_stall_cnt", 32'(hz0.stall_cnt), FWD ? 32'd1 : 32'd2);
    chk("seq_stall_cnt1",32'(hz1.stall_cnt), FWD ? 32'd1 : 32'd2);

    // Single branch: 3-cycle window on u_dut, 1-cycle on u_dut1
    reset_pulse();
    for (int c = 0; c < 4; c++) begin
      drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, (c == 0));
      #1;
      chk($sformatf("br1_c%0d_flush_if", c),  32'(hz0.flush_if),  32'(c < 3));
      chk($sformatf("br1_c%0d_flush_id", c),  32'(hz0.flush_id),  32'(c < 3));
      chk($sformatf("br1_c%0d_freeze", c),    32'(hz0.freeze),    32'd0);
      chk($sformatf("br1_c%0d_state", c),     32'(hz0.state),     (c == 1 || c == 2) ? 32'd2 : 32'd0);
      chk($sformatf("br1_c%0d_flush_if1", c), 32'(hz1.flush_if),  32'(c == 0));
      chk($sformatf("br1_c%0d_state1", c),    32'(hz1.state),     32'd0);
      next_cycle();
    end
    chk("br1_flush_cnt",  32'(hz0.flush_cnt), 32'd1);
    chk("br1_flush_cnt1", 32'(hz1.flush_cnt), 32'd1);

    // Back-to-back branches restart the window
    for (int c = 0; c < 5; c++) begin
      drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, (c < 2));
      #1;
      chk($sformatf("br2_c%0d_flush_if", c), 32'(hz0.flush_if), 32'(c < 4));
      next_cycle();
    end
    chk("br2_flush_cnt", 32'(hz0.flush_cnt), 32'd3);

    // Branch together with hazard
    reset_pulse();
    drive_hazard(1'b1);
    #1;
    chk("brhz_freeze",   32'(hz0.freeze),   32'd0);
    chk("brhz_flush_if", 32'(hz0.flush_if), 32'd1);
    chk("brhz_flush_id", 32'(hz0.flush_id), 32'd1);
    chk("brhz_freeze1",  32'(hz1.freeze),   32'd0);
    next_cycle();
    drive_hazard(1'b0);
    #1;
    chk("brhz_state",    32'(hz0.state),    32'd2);
    chk("brhz_win_frz",  32'(hz0.freeze),   32'd0);
    chk("brhz_state1",   32'(hz1.state),    32'd0);
    chk("brhz_freeze1b", 32'(hz1.freeze),   32'd1);
    next_cycle();
    chk("brhz_state1b",  32'(hz1.state),    32'd1);
    drive_idle();
    next_cycle();
    chk("brhz_stall_cnt",  32'(hz0.stall_cnt), 32'd0);
    chk("brhz_stall_cnt1", 32'(hz1.stall_cnt), 32'd1);
    chk("brhz_flush_cnt",  32'(hz0.flush_cnt), 32'd1);

    // Reset asserted in the middle of a flush window
    drive_hazard(1'b0);
    next_cycle();
    drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    next_cycle();
    drive_idle();
    #1;
    chk("mid_pre_state", 32'(hz0.state), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_state",    32'(hz0.state),     32'd0);
    chk("mid_flush_if", 32'(hz0.flush_if),  32'd0);
    chk("mid_flush_id", 32'(hz0.flush_id),  32'd0);
    chk("mid_freeze",   32'(hz0.freeze),    32'd0);
    chk("mid_stall",    32'(hz0.stall_cnt), 32'd0);
    chk("mid_flushc",   32'(hz0.flush_cnt), 32'd0);
    chk("mid_stall1",   32'(hz1.stall_cnt), 32'd0);
    rst = 1'b0;
    next_cycle();

    // 20 hazard cycles: 4-bit counter saturates, 16-bit does not
    reset_pulse();
    drive_hazard(1'b0);
    repeat (20) next_cycle();
    chk("sat_stall_cnt",  32'(hz0.stall_cnt), 32'd15);
    chk("sat_stall_cnt1", 32'(hz1.stall_cnt), 32'd20);
    chk("sat_state",      32'(hz0.state),     32'd1);
    drive_idle();
    next_cycle();
    chk("sat_hold",       32'(hz0.stall_cnt), 32'd15);
    chk("sat_run",        32'(hz0.state),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
